// File: rtl/apb_pkg.sv
// apb_pkg: constants and types shared by the APB initiator and completers.
// Holds segment widths, the initiator state type and a counter-width helper.
package apb_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Width of a counter that must reach t; never narrower than one bit.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_master.sv
// apb_master: valid/ready command stream to single APB transfers.
// Runs SETUP/ACCESS, honours wait states, aborts on a wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    apb_state_e        state_q, state_d;
    logic              live_q, live_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tout_q, tout_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    // State and captured-command registers; everything clears on reset.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tout_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tout_q  <= tout_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: capture, wait-state counting, response capture.
    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tout_d  = tout_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && live_q) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rdata_d = write_q ? '0 : prdata;
                    tout_d  = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    rdata_d = '0;
                    tout_d  = 1'b1;
                    state_d = RESP;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // live_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready   = (state_q == IDLE) && live_q;
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = tout_q;
    assign paddr       = addr_q;
    assign pwrite      = write_q;
    assign pwdata      = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master with a behavioural
// mean-accelerator completer model (regs 1-4, start at 0, result at 5).
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW        = APB_ADDR_W;
    localparam int DW        = APB_DATA_W;
    localparam int TO        = 4;
    localparam int MEAN_WAIT = 2;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic          hang = 1'b0;
    int            hold_cnt = 0;
    logic [DW-1:0] pmem [0:7] = '{default: '0};
    logic [DW-1:0] ref_mem [0:7] = '{default: '0};

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          to;
    } exp_t;
    exp_t sbq[$];

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    // Completer: result register stalls MEAN_WAIT cycles; hang stalls forever.
    always_comb begin
        prdata = pmem[paddr[2:0]];
        pready = 1'b1;
        if (hang) pready = 1'b0;
        else if (psel && penable && paddr == AW'(5) && hold_cnt < MEAN_WAIT)
            pready = 1'b0;
    end

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (psel && penable && !pready) hold_cnt <= hold_cnt + 1;
        else if (!psel) hold_cnt <= 0;
        if (psel && penable && pready && pwrite) begin
            pmem[paddr[2:0]] <= pwdata;
            if (paddr == '0 && pwdata == DW'(1))
                pmem[5] <= DW'((32'(pmem[1]) + 32'(pmem[2])
                               + 32'(pmem[3]) + 32'(pmem[4])) >> 2);
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic exp_to,
                            input bit keep, output int acc, output bit ok);
        exp_t e;
        int   s;
        e.to    = exp_to;
        e.rdata = (w || exp_to) ? '0 : ref_mem[a[2:0]];
        sbq.push_back(e);
        if (w && !exp_to) begin
            if (a == '0 && d == DW'(1)) begin
                s = int'(ref_mem[1]) + int'(ref_mem[2])
                  + int'(ref_mem[3]) + int'(ref_mem[4]);
                ref_mem[5] = DW'(s / 4);
            end
            ref_mem[a[2:0]] = d;
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge pclk);
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept addr=%0d got no cmd_ready, exp cmd_ready=1 within 40 cycles", a);
        end else begin
            @(posedge pclk);
            @(negedge pclk);
            acc = cyc;
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [DW-1:0] rd, output logic to,
                           output int rc, output int waits,
                           output int sel, output int en, output bit ok);
        rd = '0; to = 1'b0; rc = 0; waits = 0; sel = 0; en = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                ok = 1'b1; rd = rsp_rdata; to = rsp_timeout; rc = cyc;
                break;
            end
            if (psel) sel++;
            if (penable) en++;
            if (psel && penable && !pready) waits++;
            @(negedge pclk);
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rsp_wait got no rsp_valid, exp rsp_valid=1 within 40 cycles");
        end
    endtask

    task automatic test_reset();
        #1 preset_n = 1'b0;
        @(negedge pclk);
        n_chk++;
        if ({psel, penable, pwrite, rsp_valid, rsp_timeout, cmd_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b exp 000000",
                     {psel, penable, pwrite, rsp_valid, rsp_timeout, cmd_ready});
        end
        n_chk++;
        if ({paddr, pwdata, rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp 0", paddr, pwdata, rsp_rdata);
        end
        preset_n = 1'b1;
        #1;
        n_chk++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rel_pre got cmd_ready=%b exp 0", cmd_ready);
        end
        @(negedge pclk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_rel_post got cmd_ready=%b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        logic [DW-1:0] rd; logic to; int acc, rc, wt, sl, en; bit ok;
        exp_t e;
        send_cmd(1'b1, AW'(1), 16'h1234, 1'b0, 1'b0, acc, ok);
        n_chk++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, AW'(1), 16'h1234}) begin
            n_fail++;
            $display("FAIL wr_setup got sel/en/wr=%b%b%b addr=%h wdata=%h exp 101 001 1234",
                     psel, penable, pwrite, paddr, pwdata);
        end
        get_rsp(rd, to, rc, wt, sl, en, ok);
        n_chk++;
        if (sl !== 2 || en !== 1) begin
            n_fail++; $display("FAIL wr_phases got psel=%0d penable=%0d cycles exp 2 1", sl, en);
        end
        n_chk++;
        if (rc - acc + 1 !== 3) begin
            n_fail++; $display("FAIL wr_latency got %0d exp 3", rc - acc + 1);
        end
        e = sbq.pop_front();
        n_chk++;
        if (rd !== e.rdata || to !== e.to) begin
            n_fail++;
            $display("FAIL wr_rsp got rdata=%h to=%b exp rdata=%h to=%b", rd, to, e.rdata, e.to);
        end
        @(negedge pclk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready_n4 got cmd_ready=%b exp 1", cmd_ready);
        end
    endtask

    task automatic test_mean();
        logic [DW-1:0] rd; logic to; int acc, rc, wt, sl, en; bit ok;
        exp_t e;
        logic [AW-1:0] wa [0:4] = '{AW'(1), AW'(2), AW'(3), AW'(4), AW'(0)};
        logic [DW-1:0] wd [0:4] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd1};
        for (int k = 0; k < 5; k++) begin
            send_cmd(1'b1, wa[k], wd[k], 1'b0, 1'b0, acc, ok);
            get_rsp(rd, to, rc, wt, sl, en, ok);
            e = sbq.pop_front();
            n_chk++;
            if (rd !== e.rdata || to !== e.to) begin
                n_fail++;
                $display("FAIL mean_wr%0d got rdata=%h to=%b exp rdata=%h to=%b",
                         k, rd, to, e.rdata, e.to);
            end
            @(negedge pclk);
        end
        send_cmd(1'b0, AW'(5), '0, 1'b0, 1'b0, acc, ok);
        get_rsp(rd, to, rc, wt, sl, en, ok);
        e = sbq.pop_front();
        n_chk++;
        if (rd !== e.rdata || to !== e.to || rd !== 16'h0019) begin
            n_fail++;
            $display("FAIL mean_rd got rdata=%h to=%b exp rdata=%h to=%b",
                     rd, to, e.rdata, e.to);
        end
        n_chk++;
        if (wt !== MEAN_WAIT) begin
            n_fail++; $display("FAIL mean_waits got %0d exp %0d", wt, MEAN_WAIT);
        end
        n_chk++;
        if (rc - acc + 1 - 3 !== wt) begin
            n_fail++; $display("FAIL mean_latency got extra %0d exp %0d", rc - acc - 2, wt);
        end
        @(negedge pclk);
    endtask

    task automatic test_rsp_stall();
        logic [DW-1:0] rd; logic to; int acc, rc, wt, sl, en; bit ok;
        exp_t e;
        rsp_ready = 1'b0;
        send_cmd(1'b0, AW'(5), '0, 1'b0, 1'b0, acc, ok);
        get_rsp(rd, to, rc, wt, sl, en, ok);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            n_chk++;
            if ({rsp_valid, cmd_ready} !== 2'b10 || rsp_rdata !== rd) begin
                n_fail++;
                $display("FAIL stall%0d got valid=%b ready=%b rdata=%h exp 1 0 %h",
                         k, rsp_valid, cmd_ready, rsp_rdata, rd);
            end
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        n_chk++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release got valid=%b ready=%b exp 0 1", rsp_valid, cmd_ready);
        end
        e = sbq.pop_front();
        n_chk++;
        if (rd !== e.rdata || to !== e.to) begin
            n_fail++;
            $display("FAIL stall_rsp got rdata=%h to=%b exp rdata=%h to=%b", rd, to, e.rdata, e.to);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd; logic to; int acc, rc, wt, sl, en; bit ok;
        exp_t e;
        hang = 1'b1;
        send_cmd(1'b0, AW'(2), '0, 1'b1, 1'b0, acc, ok);
        get_rsp(rd, to, rc, wt, sl, en, ok);
        n_chk++;
        if (wt !== TO || sl !== TO + 1 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL to_waits got waits=%0d psel_cyc=%0d psel=%b exp %0d %0d 0",
                     wt, sl, psel, TO, TO + 1);
        end
        e = sbq.pop_front();
        n_chk++;
        if (rd !== e.rdata || to !== e.to) begin
            n_fail++;
            $display("FAIL to_rsp got rdata=%h to=%b exp rdata=%h to=%b", rd, to, e.rdata, e.to);
        end
        @(negedge pclk);
        hang = 1'b0;
        send_cmd(1'b1, AW'(6), 16'h00aa, 1'b0, 1'b0, acc, ok);
        get_rsp(rd, to, rc, wt, sl, en, ok);
        e = sbq.pop_front();
        n_chk++;
        if (rd !== e.rdata || to !== e.to || rc - acc + 1 !== 3) begin
            n_fail++;
            $display("FAIL to_next got rdata=%h to=%b lat=%0d exp rdata=%h to=%b lat=3",
                     rd, to, rc - acc + 1, e.rdata, e.to);
        end
        @(negedge pclk);
    endtask

    task automatic test_reset_mid();
        int acc; bit ok; bit seen;
        hang = 1'b1;
        send_cmd(1'b0, AW'(3), '0, 1'b0, 1'b0, acc, ok);
        @(negedge pclk);
        n_chk++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++; $display("FAIL rmid_access got sel/en=%b%b exp 11", psel, penable);
        end
        #2 preset_n = 1'b0;
        #1;
        n_chk++;
        if ({psel, penable, rsp_valid, cmd_ready, pwrite} !== 5'b0 || paddr !== '0) begin
            n_fail++;
            $display("FAIL rmid_async got sel/en/valid/ready/wr=%b%b%b%b%b addr=%h exp 0",
                     psel, penable, rsp_valid, cmd_ready, pwrite, paddr);
        end
        sbq.delete();
        @(negedge pclk);
        hang = 1'b0;
        preset_n = 1'b1;
        @(negedge pclk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_ready got cmd_ready=%b exp 1", cmd_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge pclk);
        end
        n_chk++;
        if (seen) begin
            n_fail++; $display("FAIL rmid_norsp got rsp_valid=1 exp no response");
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd; logic to; int acc, prev, rc, wt, sl, en; bit ok;
        exp_t e;
        logic [AW-1:0] ra [0:2] = '{AW'(1), AW'(2), AW'(3)};
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            send_cmd(1'b0, ra[k], '0, 1'b0, k < 2, acc, ok);
            if (k > 0) begin
                n_chk++;
                if (acc - prev !== 4) begin
                    n_fail++; $display("FAIL b2b_rate%0d got %0d exp 4", k, acc - prev);
                end
            end
            prev = acc;
            n_chk++;
            if ({psel, penable} !== 2'b10 || paddr !== ra[k]) begin
                n_fail++;
                $display("FAIL b2b_setup%0d got sel/en=%b%b addr=%h exp 10 %h",
                         k, psel, penable, paddr, ra[k]);
            end
            @(negedge pclk);
            n_chk++;
            if ({psel, penable} !== 2'b11 || paddr !== ra[k]) begin
                n_fail++;
                $display("FAIL b2b_access%0d got sel/en=%b%b addr=%h exp 11 %h",
                         k, psel, penable, paddr, ra[k]);
            end
            get_rsp(rd, to, rc, wt, sl, en, ok);
            e = sbq.pop_front();
            n_chk++;
            if (rd !== e.rdata || to !== e.to) begin
                n_fail++;
                $display("FAIL b2b_rsp%0d got rdata=%h to=%b exp rdata=%h to=%b",
                         k, rd, to, e.rdata, e.to);
            end
        end
        cmd_valid = 1'b0;
        @(negedge pclk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_mean();
        test_rsp_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no end of test, exp completion within 200000 time units");
        $fatal(1);
    end

endmodule
